// File: rtl/counter_seq_ctrl_pkg.sv
// Shared constants for the display-counter sequencer: state encoding and default sizing.
package counter_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned DEF_W         = 10;
    localparam int unsigned DEF_MAX_COUNT = 999;
    localparam int unsigned DEF_TICK_DIV  = 50000000;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Button/switch inputs and counter-control outputs of the sequencer, grouped as one bundle.
interface counter_seq_ctrl_if import counter_seq_ctrl_pkg::*; #(
    parameter int unsigned W = DEF_W
) ();

    logic         btn_start_stop;
    logic         btn_dir;
    logic         btn_load;
    logic [W-1:0] sw_data;
    logic [W-1:0] cnt_value;

    logic         cnt_en;
    logic         cnt_up;
    logic         cnt_load;
    logic [W-1:0] cnt_data;
    logic         running;
    logic         done;
    logic         wrap_pulse;

    modport slave (
        input  btn_start_stop, btn_dir, btn_load, sw_data, cnt_value,
        output cnt_en, cnt_up, cnt_load, cnt_data, running, done, wrap_pulse
    );

    modport master (
        output btn_start_stop, btn_dir, btn_load, sw_data, cnt_value,
        input  cnt_en, cnt_up, cnt_load, cnt_data, running, done, wrap_pulse
    );

endinterface

// File: rtl/counter_seq_ctrl_tick_gen.sv
// Prescaler with synchronous clear: o_tick is high on the last count of every TICK_DIV period.
module counter_seq_ctrl_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned     CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] Last = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == Last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == Last);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a loadable up/down counter: paces steps with a one-cycle enable, pauses,
// loads presets and stops or wraps at the bounds using the read-back counter value.
module counter_seq_ctrl import counter_seq_ctrl_pkg::*; #(
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned W         = DEF_W,
    parameter int unsigned MAX_COUNT = DEF_MAX_COUNT,
    parameter bit          WRAP      = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    counter_seq_ctrl_if.slave ctrl_if
);

    localparam logic [W-1:0] MaxVal = W'(MAX_COUNT);

    logic [1:0]   r_state;
    logic [1:0]   w_state_d;
    logic         r_en, r_up, r_load, r_wrap, r_running, r_done;
    logic [W-1:0] r_data;
    logic         w_en_d, w_up_d, w_load_d, w_wrap_d;
    logic [W-1:0] w_data_d;
    logic [W-1:0] w_sw_clamped;
    logic         w_tick, w_terminal, w_clr;

    // Held clear on both sides of RUN so a resume always starts a full period.
    assign w_clr = (r_state != ST_RUN) || (w_state_d != ST_RUN);

    counter_seq_ctrl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .o_tick  (w_tick)
    );

    assign w_sw_clamped = (ctrl_if.sw_data > MaxVal) ? MaxVal : ctrl_if.sw_data;
    assign w_terminal   = r_up ? (ctrl_if.cnt_value >= MaxVal) : (ctrl_if.cnt_value == '0);

    always_comb begin
        w_state_d = r_state;
        w_en_d    = 1'b0;
        w_load_d  = 1'b0;
        w_wrap_d  = 1'b0;
        w_data_d  = r_data;
        w_up_d    = r_up ^ ctrl_if.btn_dir;
        case (r_state)
            ST_RUN: begin
                // Pause beats a coincident tick; load requests are ignored while running.
                if (ctrl_if.btn_start_stop) begin
                    w_state_d = ST_PAUSE;
                end else if (w_tick) begin
                    if (!w_terminal) begin
                        w_en_d = 1'b1;
                    end else if (WRAP) begin
                        w_load_d = 1'b1;
                        w_wrap_d = 1'b1;
                        w_data_d = r_up ? '0 : MaxVal;
                    end else begin
                        w_state_d = ST_DONE;
                    end
                end
            end
            default: begin
                if (ctrl_if.btn_load) begin
                    w_load_d  = 1'b1;
                    w_data_d  = w_sw_clamped;
                    w_state_d = ST_IDLE;
                end else if (ctrl_if.btn_start_stop) begin
                    w_state_d = (r_state == ST_DONE) ? ST_IDLE : ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_up      <= 1'b1;
            r_load    <= 1'b0;
            r_wrap    <= 1'b0;
            r_data    <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_en      <= w_en_d;
            r_up      <= w_up_d;
            r_load    <= w_load_d;
            r_wrap    <= w_wrap_d;
            r_data    <= w_data_d;
            r_running <= (w_state_d == ST_RUN);
            r_done    <= (w_state_d == ST_DONE);
        end
    end

    assign ctrl_if.cnt_en     = r_en;
    assign ctrl_if.cnt_up     = r_up;
    assign ctrl_if.cnt_load   = r_load;
    assign ctrl_if.cnt_data   = r_data;
    assign ctrl_if.running    = r_running;
    assign ctrl_if.done       = r_done;
    assign ctrl_if.wrap_pulse = r_wrap;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a stopping (WRAP=0) and a wrapping (WRAP=1) instance share stimulus;
// each drives an emulated counter and is compared against a behavioural model.
module tb_counter_seq_ctrl;
    import counter_seq_ctrl_pkg::*;

    localparam int unsigned W    = DEF_W;
    localparam int          TD   = 4;
    localparam int          MAXC = 9;
    localparam logic [15:0] RST_VEC = {6'b010000, 10'd0};

    logic         clk;
    logic         rst_n;
    logic         b_ss, b_dir, b_ld;
    logic [W-1:0] sw;
    logic [W-1:0] c0, c1;

    int n_checks = 0;
    int n_errors = 0;

    counter_seq_ctrl_if #(.W(W)) bus0 ();
    counter_seq_ctrl_if #(.W(W)) bus1 ();

    counter_seq_ctrl #(.TICK_DIV(TD), .W(W), .MAX_COUNT(MAXC), .WRAP(1'b0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .ctrl_if (bus0.slave)
    );

    counter_seq_ctrl #(.TICK_DIV(TD), .W(W), .MAX_COUNT(MAXC), .WRAP(1'b1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .ctrl_if (bus1.slave)
    );

    assign bus0.btn_start_stop = b_ss;
    assign bus0.btn_dir        = b_dir;
    assign bus0.btn_load       = b_ld;
    assign bus0.sw_data        = sw;
    assign bus0.cnt_value      = c0;
    assign bus1.btn_start_stop = b_ss;
    assign bus1.btn_dir        = b_dir;
    assign bus1.btn_load       = b_ld;
    assign bus1.sw_data        = sw;
    assign bus1.cnt_value      = c1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Emulated bin_count_load counters, one per DUT, driven by that DUT's outputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0 <= '0;
            c1 <= '0;
        end else begin
            if (bus0.cnt_load)    c0 <= bus0.cnt_data;
            else if (bus0.cnt_en) c0 <= bus0.cnt_up ? c0 + 10'd1 : c0 - 10'd1;
            if (bus1.cnt_load)    c1 <= bus1.cnt_data;
            else if (bus1.cnt_en) c1 <= bus1.cnt_up ? c1 + 10'd1 : c1 - 10'd1;
        end
    end

    // Behavioural reference: index 0 stops at the bound, index 1 wraps.
    typedef enum int {MIdle, MRun, MPause, MDone} mmode_t;
    mmode_t m_mode [2];
    int     m_phase[2];
    int     m_val  [2];
    int     e_data [2];
    bit     m_up   [2];
    bit     e_en   [2];
    bit     e_load [2];
    bit     e_wrap [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]  = MIdle;
            m_phase[k] = 0;
            m_val[k]   = 0;
            e_data[k]  = 0;
            m_up[k]    = 1'b1;
            e_en[k]    = 1'b0;
            e_load[k]  = 1'b0;
            e_wrap[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            mmode_t nm;
            int     nv, nd;
            bit     tick, term, en, ld, wr;
            nm = m_mode[k];
            nd = e_data[k];
            en = 1'b0;
            ld = 1'b0;
            wr = 1'b0;
            nv = m_val[k];
            if (e_load[k])    nv = e_data[k];
            else if (e_en[k]) nv = m_up[k] ? (m_val[k] + 1) % 1024 : (m_val[k] + 1023) % 1024;
            tick = (m_mode[k] == MRun) && (m_phase[k] == TD - 1);
            term = m_up[k] ? (m_val[k] >= MAXC) : (m_val[k] == 0);
            if (m_mode[k] == MRun) begin
                if (b_ss) nm = MPause;
                else if (tick && !term) en = 1'b1;
                else if (tick && k == 1) begin
                    ld = 1'b1;
                    wr = 1'b1;
                    nd = m_up[k] ? 0 : MAXC;
                end else if (tick) nm = MDone;
            end else if (b_ld) begin
                ld = 1'b1;
                nd = (int'(sw) > MAXC) ? MAXC : int'(sw);
                nm = MIdle;
            end else if (b_ss) begin
                nm = (m_mode[k] == MDone) ? MIdle : MRun;
            end
            m_phase[k] = (nm == MRun && m_mode[k] == MRun) ? (m_phase[k] + 1) % TD : 0;
            m_mode[k]  = nm;
            m_val[k]   = nv;
            m_up[k]    = m_up[k] ^ b_dir;
            e_en[k]    = en;
            e_load[k]  = ld;
            e_wrap[k]  = wr;
            e_data[k]  = nd;
        end
    endtask

    function automatic logic [15:0] obs(input int k);
        if (k == 0)
            return {bus0.cnt_en, bus0.cnt_up, bus0.cnt_load, bus0.wrap_pulse,
                    bus0.running, bus0.done, bus0.cnt_data};
        return {bus1.cnt_en, bus1.cnt_up, bus1.cnt_load, bus1.wrap_pulse,
                bus1.running, bus1.done, bus1.cnt_data};
    endfunction

    function automatic logic [15:0] expv(input int k);
        return {e_en[k], m_up[k], e_load[k], e_wrap[k],
                m_mode[k] == MRun, m_mode[k] == MDone, 10'(e_data[k])};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse(input bit ss, input bit dir, input bit ld);
        b_ss  = ss;
        b_dir = dir;
        b_ld  = ld;
        step();
        b_ss  = 1'b0;
        b_dir = 1'b0;
        b_ld  = 1'b0;
    endtask

    task automatic test_reset();
        int en_seen;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs(k) !== RST_VEC) begin
                n_errors++;
                $display("FAIL reset_outputs dut%0d: got %h want %h", k, obs(k), RST_VEC);
            end
        end
        en_seen = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (bus0.cnt_en || bus0.running) en_seen++;
        end
        n_checks++;
        if (en_seen != 0) begin
            n_errors++;
            $display("FAIL idle_quiet: got %0d active cycles want 0", en_seen);
        end
    endtask

    task automatic test_count_up();
        int en_cnt, done_at;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus0.running !== 1'b1) begin
            n_errors++;
            $display("FAIL start_running: got %b want 1", bus0.running);
        end
        en_cnt  = 0;
        done_at = -1;
        for (int n = 1; n <= 56; n++) begin
            step();
            if (bus0.cnt_en) begin
                en_cnt++;
                n_checks++;
                if (n != 4 * en_cnt) begin
                    n_errors++;
                    $display("FAIL up_en_timing: got cycle %0d want %0d", n, 4 * en_cnt);
                end
            end
            if (bus0.done && done_at < 0) done_at = n;
            if (n == 40) begin
                n_checks++;
                if ({bus1.cnt_load, bus1.wrap_pulse, bus1.running, bus1.cnt_data} !== {3'b111, 10'd0}) begin
                    n_errors++;
                    $display("FAIL wrap_up: got ld/wp/run/data %b%b%b/%0d want 111/0", bus1.cnt_load,
                             bus1.wrap_pulse, bus1.running, bus1.cnt_data);
                end
            end
        end
        n_checks++;
        if (en_cnt != 9 || c0 !== 10'd9) begin
            n_errors++;
            $display("FAIL up_count: got %0d enables value %0d want 9 enables value 9", en_cnt, c0);
        end
        n_checks++;
        if (done_at != 40 || bus0.running !== 1'b0) begin
            n_errors++;
            $display("FAIL up_done: got done at %0d running %b want 40 running 0", done_at, bus0.running);
        end
    endtask

    task automatic test_load_clamp_down();
        int en_cnt, done_at;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({bus0.running, bus0.done} !== 2'b00) begin
            n_errors++;
            $display("FAIL done_to_idle: got run/done %b%b want 00", bus0.running, bus0.done);
        end
        sw = 10'd12;
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus0.cnt_load, bus0.cnt_data} !== {1'b1, 10'd9}) begin
            n_errors++;
            $display("FAIL load_clamp: got ld %b data %0d want ld 1 data 9", bus0.cnt_load, bus0.cnt_data);
        end
        step();
        n_checks++;
        if ({bus0.cnt_load, bus0.cnt_data} !== {1'b0, 10'd9}) begin
            n_errors++;
            $display("FAIL load_hold: got ld %b data %0d want ld 0 data 9", bus0.cnt_load, bus0.cnt_data);
        end
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus0.cnt_up !== 1'b0) begin
            n_errors++;
            $display("FAIL dir_toggle: got up %b want 0", bus0.cnt_up);
        end
        pulse(1'b1, 1'b0, 1'b0);
        en_cnt  = 0;
        done_at = -1;
        for (int n = 1; n <= 56; n++) begin
            step();
            if (bus0.cnt_en) begin
                en_cnt++;
                n_checks++;
                if (n != 4 * en_cnt) begin
                    n_errors++;
                    $display("FAIL down_en_timing: got cycle %0d want %0d", n, 4 * en_cnt);
                end
            end
            if (bus0.done && done_at < 0) done_at = n;
            if (n == 40) begin
                n_checks++;
                if ({bus1.cnt_load, bus1.wrap_pulse, bus1.running, bus1.cnt_data} !== {3'b111, 10'd9}) begin
                    n_errors++;
                    $display("FAIL wrap_down: got ld/wp/run/data %b%b%b/%0d want 111/9", bus1.cnt_load,
                             bus1.wrap_pulse, bus1.running, bus1.cnt_data);
                end
            end
        end
        n_checks++;
        if (en_cnt != 9 || c0 !== 10'd0 || done_at != 40) begin
            n_errors++;
            $display("FAIL down_count: got %0d enables value %0d done at %0d want 9/0/40",
                     en_cnt, c0, done_at);
        end
    endtask

    task automatic test_pause_resume();
        int en_cnt, first_en;
        bit found;
        pulse(1'b1, 1'b0, 1'b0);
        sw = 10'd2;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            step();
            if (c0 == 10'd5) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL reach_five: got value %0d want 5 within 60 cycles", c0);
        end
        pulse(1'b1, 1'b0, 1'b0);
        en_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus0.cnt_en) en_cnt++;
            step();
        end
        n_checks++;
        if (en_cnt != 0 || bus0.running !== 1'b0 || c0 !== 10'd5) begin
            n_errors++;
            $display("FAIL paused: got %0d enables running %b value %0d want 0/0/5",
                     en_cnt, bus0.running, c0);
        end
        pulse(1'b1, 1'b0, 1'b0);
        first_en = -1;
        for (int n = 1; n <= 8 && first_en < 0; n++) begin
            step();
            if (bus0.cnt_en) first_en = n;
        end
        step();
        n_checks++;
        if (first_en != 4 || c0 !== 10'd6) begin
            n_errors++;
            $display("FAIL resume: got first enable %0d value %0d want 4 value 6", first_en, c0);
        end
    endtask

    task automatic test_load_priority();
        sw = 10'd3;
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus0.cnt_load !== 1'b0 || bus0.running !== 1'b1) begin
            n_errors++;
            $display("FAIL load_in_run: got ld %b running %b want ld 0 running 1",
                     bus0.cnt_load, bus0.running);
        end
        pulse(1'b1, 1'b0, 1'b0);
        sw = 10'd7;
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus0.cnt_load, bus0.cnt_data, bus0.running} !== {1'b1, 10'd7, 1'b0}) begin
            n_errors++;
            $display("FAIL load_in_pause: got ld %b data %0d run %b want 1/7/0",
                     bus0.cnt_load, bus0.cnt_data, bus0.running);
        end
        sw = 10'd3;
        pulse(1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({bus0.cnt_load, bus0.cnt_data, bus0.running, bus0.done} !== {1'b1, 10'd3, 2'b00}) begin
            n_errors++;
            $display("FAIL load_beats_start: got ld %b data %0d run %b done %b want 1/3/0/0",
                     bus0.cnt_load, bus0.cnt_data, bus0.running, bus0.done);
        end
        step();
        step();
        n_checks++;
        if (bus0.running !== 1'b0 || c0 !== 10'd3) begin
            n_errors++;
            $display("FAIL stays_idle: got running %b value %0d want 0 value 3", bus0.running, c0);
        end
    endtask

    task automatic test_async_reset();
        int first_en;
        pulse(1'b1, 1'b0, 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs(k) !== RST_VEC) begin
                n_errors++;
                $display("FAIL async_reset dut%0d: got %h want %h", k, obs(k), RST_VEC);
            end
        end
        step();
        rst_n = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        first_en = -1;
        for (int n = 1; n <= 8 && first_en < 0; n++) begin
            step();
            if (bus0.cnt_en) first_en = n;
        end
        n_checks++;
        if (first_en != 4) begin
            n_errors++;
            $display("FAIL post_reset_period: got first enable %0d want 4", first_en);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            b_ss  = ($urandom_range(23) == 0);
            b_dir = ($urandom_range(19) == 0);
            b_ld  = ($urandom_range(39) == 0);
            sw    = 10'($urandom_range(15));
            step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== expv(k)) begin
                    n_errors++;
                    $display("FAIL random_outputs dut%0d cycle %0d: got %h want %h", k, n, obs(k), expv(k));
                end
            end
            n_checks++;
            if (int'(c0) != m_val[0] || int'(c1) != m_val[1]) begin
                n_errors++;
                $display("FAIL random_value cycle %0d: got %0d/%0d want %0d/%0d",
                         n, c0, c1, m_val[0], m_val[1]);
            end
        end
        b_ss  = 1'b0;
        b_dir = 1'b0;
        b_ld  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        b_ss  = 1'b0;
        b_dir = 1'b0;
        b_ld  = 1'b0;
        sw    = '0;
        model_reset();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        test_reset();
        test_count_up();
        test_load_clamp_down();
        test_pause_resume();
        test_load_priority();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer for the display counter path: clkdiv-style tick generation -> bin_count_load -> BCD -> 4x seven-segment. Takes debounced button pulses and preset switches. Drives the counter's enable, up_down, load and data_in so the count advances once per tick period, pauses, reloads and stops or wraps at its bounds. Closes the loop by reading back the counter value for terminal detection. Replaces the divided-clock approach: the whole path runs on the single system clock with a one-cycle enable.

Parameters:
TICK_DIV, 50000000, system clocks per count step (>=2)
W, 10, counter/data width
MAX_COUNT, 999, upper count bound (<= 2^W-1)
WRAP, 0, 0 = stop in DONE at bound, 1 = reload and keep running

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
btn_start_stop  in  1  one-cycle pulse from debouncer
btn_dir  in  1  one-cycle pulse, toggles direction
btn_load  in  1  one-cycle pulse, load preset
sw_data  in  W  preset value
cnt_value  in  W  current counter output, read back
cnt_en  out  1  counter enable, one clk wide per step
cnt_up  out  1  counter up_down (1 = up)
cnt_load  out  1  counter synchronous load strobe
cnt_data  out  W  counter data_in
running  out  1  high in RUN
done  out  1  high in DONE
wrap_pulse  out  1  one cycle on wrap (WRAP=1 only)

Behaviour:
- Reset (rst=0, async): state IDLE, prescaler 0. Outputs: cnt_en 0, cnt_up 1, cnt_load 0, cnt_data 0, running 0, done 0, wrap_pulse 0. All outputs are registered.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- Prescaler counts 0..TICK_DIV-1 only in RUN and clears to 0 in any other state.
- Internal tick fires when prescaler = TICK_DIV-1; registered outputs follow one clk later.
- Terminal condition: (cnt_up && cnt_value >= MAX_COUNT) || (!cnt_up && cnt_value == 0).
  - Evaluated on the tick cycle.
  - TICK_DIV>=2 guarantees cnt_value has already settled from the previous step.
- RUN, tick, not terminal: cnt_en=1 for exactly one cycle.
- RUN, tick, terminal, WRAP=0: cnt_en stays 0; -> DONE.
- RUN, tick, terminal, WRAP=1: cnt_load=1 with cnt_data = cnt_up ? 0 : MAX_COUNT, plus wrap_pulse=1 for one cycle; state stays RUN.
- btn_start_stop transitions:
  - IDLE -> RUN
  - RUN -> PAUSE (prescaler cleared, so resume gives a full period)
  - PAUSE -> RUN
  - DONE -> IDLE
- btn_load in IDLE, PAUSE or DONE:
  - cnt_load=1 for one cycle.
  - cnt_data = sw_data clamped to MAX_COUNT (sw_data > MAX_COUNT loads MAX_COUNT).
  - Next state IDLE.
- btn_load in RUN: ignored.
- btn_dir: toggles cnt_up in any state. Takes effect from the next tick. In DONE it does not leave DONE; only start_stop does.
- Simultaneous pulses, one cycle:
  - btn_load wins over btn_start_stop; start is dropped.
  - btn_dir is always applied.
  - An internal tick coinciding with btn_start_stop (RUN->PAUSE): pause wins and no cnt_en is issued.
- cnt_load and cnt_en are never high in the same cycle.
- cnt_data holds its last value whenever cnt_load=0.
- running = (state==RUN); done = (state==DONE).
- Reset asserted mid-operation: immediate return to reset values. Any partially elapsed tick period is discarded.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE) and default W/MAX_COUNT, reused by the top level and the bench.
- One natural sub-module: tick_gen. Parameter TICK_DIV; inputs clk, rst, clr; output tick. It is the prescaler with synchronous clear and is reused elsewhere in place of clkdiv.
- FSM and output registers stay in counter_seq_ctrl.

Test Plan:
(TICK_DIV=4, MAX_COUNT=9, WRAP=0; bench models the counter from cnt_en, cnt_up, cnt_load, cnt_data.)
1. Reset, then btn_start_stop -> running=1; cnt_en one cycle every 4 clks; model counts 0,1,..9; 4 clks after reaching 9 done=1, running=0, no further cnt_en.
2. In DONE, btn_start_stop -> IDLE. sw_data=12, btn_load -> cnt_load one cycle with cnt_data=9 (clamped). btn_dir, start -> counts 9,8..0, then DONE.
3. RUN at value 5, btn_start_stop -> PAUSE, no cnt_en for 20 clks. Start again -> first cnt_en exactly 4 clks later, value 6.
4. btn_load and btn_start_stop same cycle in IDLE, sw_data=3 -> cnt_load=1, cnt_data=3, state stays IDLE. btn_load during RUN -> no cnt_load.
5. WRAP=1, up, value reaches 9 -> next tick gives cnt_load=1, cnt_data=0, wrap_pulse=1, still running. Down from 0 -> cnt_data=9.
6. rst=0 asynchronously mid-period in RUN -> all outputs at reset values the same cycle. After release, first start gives a full 4-clk period before cnt_en.
